// File: rtl/muldiv_iter.sv
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative signed/unsigned multiply and divide unit (one bit per clock).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_bzero;
  logic [WIDTH-1:0]     r_a_orig;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits still to consume / quotient bits}.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_trial    = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = {(w_ge ? w_trial : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_prod = r_sign_q ? -r_acc : r_acc;
  assign w_quo  = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE,
        S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
        S_RUN:   w_next = (r_cnt == c_last_iter) ? S_FIX : S_RUN;
        S_FIX:   w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= 2'b00;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_orig <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_sign_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_sign_r <= w_signed & a[WIDTH-1];
      r_bzero  <= (b == '0);
      r_a_orig <= a;
      r_cnt    <= '0;
      if (op[1]) begin
        r_opnd <= w_b_mag;
        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
      end else begin
        r_opnd <= w_a_mag;
        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= r_op[1] ? w_div_next : w_mul_next;
    end else if ((r_state == S_FIX) && !flush) begin
      if (!r_op[1]) begin
        r_hi  <= w_prod[2*WIDTH-1:WIDTH];
        r_lo  <= w_prod[WIDTH-1:0];
        r_dbz <= 1'b0;
      end else if (r_bzero) begin
        // Divide by zero reports the untouched dividend; no sign fix applies.
        r_hi  <= r_a_orig;
        r_lo  <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_hi  <= w_rem;
        r_lo  <= w_quo;
        r_dbz <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter.sv
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          start_edge;
    string       name;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;
  logic        flush8 = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   busy_cnt = 0;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  muldiv_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // 32-bit monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: actual=1 expected=0 at edge %0d", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
        chk({e.name, "_latency"}, 64'(cyc - e.start_edge), 64'd33);
        chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done8: actual=1 expected=0 at edge %0d", cyc);
      end else begin
        e = q8.pop_front();
        chk({e.name, "_hi"}, 64'(hi8), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo8), 64'(e.lo));
        chk({e.name, "_dbz"}, 64'(dbz8), 64'(e.dbz));
        chk({e.name, "_latency"}, 64'(cyc - e.start_edge), 64'd9);
      end
    end
  end

  // Called at a negedge; holds start for exactly one rising edge.
  task automatic issue(input vec_t v);
    exp_t e;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz; e.start_edge = cyc + 1; e.name = v.name;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input vec_t v);
    exp_t e;
    op8 = v.op; a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
    e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz; e.start_edge = cyc + 1; e.name = v.name;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: actual=no_done expected=done", name);
    end
  endtask

  task automatic wait_done8(input string name);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      checks++;
      $display("FAIL %s_timeout: actual=no_done expected=done", name);
    end
  endtask

  vec_t vecs[$] = '{
    '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"},
    '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1_m1"},
    '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3_7"},
    '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min_min"},
    '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"},
    '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2"},
    '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, "divu_7_2"},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_overflow"},
    '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_max_1"},
    '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, "divu_by_zero"},
    '{2'b11, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0, "divu_10_3"},
    '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_neg_by_zero"}
  };

  vec_t vecs8[$] = '{
    '{2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, "w8_multu_max"},
    '{2'b00, 32'hF9, 32'h03, 32'hFF, 32'hEB, 1'b0, "w8_mult_m7_3"},
    '{2'b10, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, "w8_div_m7_2"},
    '{2'b11, 32'h80, 32'h00, 32'h80, 32'hFF, 1'b1, "w8_divu_by_zero"},
    '{2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, "w8_div_overflow"}
  };

  initial begin
    logic [31:0] save_hi, save_lo;
    logic        save_dbz;
    exp_t        dropped;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i]);
      wait_done(vecs[i].name);
    end

    // Back-to-back: second start lands in the DONE cycle.
    @(negedge clk);
    issue('{2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "b2b_first"});
    wait_done("b2b_first");
    issue('{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "b2b_second"});
    wait_done("b2b_second");

    // Flush mid-run with a simultaneous start.
    @(negedge clk);
    save_hi = hi; save_lo = lo; save_dbz = dbz;
    issue('{2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, "flushed"});
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    dropped = q.pop_back();
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi_hold", 64'(hi), 64'(save_hi));
    chk("flush_lo_hold", 64'(lo), 64'(save_lo));
    chk("flush_dbz_hold", 64'(dbz), 64'(save_dbz));
    repeat (40) @(negedge clk);

    // Flush and start together while idle: start is dropped.
    flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("idle_flush_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Start during a run is ignored.
    issue('{2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "ignore_start"});
    repeat (14) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start");

    // Reset mid-run after a divide-by-zero left the flag set.
    @(negedge clk);
    issue('{2'b11, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1'b1, "pre_reset_dbz"});
    wait_done("pre_reset_dbz");
    @(negedge clk);
    issue('{2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "reset_victim"});
    repeat (10) @(negedge clk);
    reset = 1'b1;
    dropped = q.pop_back();
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_hi", 64'(hi), 64'd0);
    chk("midrun_reset_lo", 64'(lo), 64'd0);
    chk("midrun_reset_dbz", 64'(dbz), 64'd0);
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    issue('{2'b11, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, "post_reset_divu"});
    wait_done("post_reset_divu");

    foreach (vecs8[i]) begin
      @(negedge clk);
      issue8(vecs8[i]);
      wait_done8(vecs8[i].name);
    end

    repeat (3) @(negedge clk);
    chk("q32_drained", 64'(q.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
